// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: output/oe registers with masked writes, synchronized and glitch-filtered pad inputs, edge interrupts
module gpio_pad_ctrl #(
  parameter int NumPins = 8,
  parameter int CntW    = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               out_wr_i,
  input  logic               oe_wr_i,
  input  logic [NumPins-1:0] wr_mask_i,
  input  logic [NumPins-1:0] wr_data_i,
  input  logic [NumPins-1:0] ie_i,
  input  logic [NumPins-1:0] filter_en_i,
  input  logic [CntW-1:0]    filter_thresh_i,
  input  logic [NumPins-1:0] intr_rise_en_i,
  input  logic [NumPins-1:0] intr_fall_en_i,
  input  logic [NumPins-1:0] intr_clr_i,
  output logic [NumPins-1:0] pad_out_o,
  output logic [NumPins-1:0] pad_oe_o,
  output logic [NumPins-1:0] pad_ie_o,
  input  logic [NumPins-1:0] pad_in_i,
  output logic [NumPins-1:0] data_in_o,
  output logic [NumPins-1:0] intr_state_o,
  output logic               intr_o
);
  logic [NumPins-1:0] out_q, out_d, oe_q, oe_d, ie_q;
  logic [NumPins-1:0] sync1_q, sync2_q;
  logic [NumPins-1:0] filt_q, filt_d, intr_q, intr_d;
  logic [CntW-1:0]    cnt_q [NumPins];
  logic [CntW-1:0]    cnt_d [NumPins];
  logic [CntW-1:0]    thr_m1;
  // masked read-modify-write of the output and output-enable registers
  always_comb begin
    out_d = out_wr_i ? (out_q & ~wr_mask_i) | (wr_data_i & wr_mask_i) : out_q;
    oe_d  = oe_wr_i  ? (oe_q  & ~wr_mask_i) | (wr_data_i & wr_mask_i) : oe_q;
  end
  // glitch filter: a new level is accepted once it has been seen for T consecutive cycles
  always_comb begin
    thr_m1 = (filter_thresh_i == '0) ? '0 : filter_thresh_i - 1'b1;
    for (int i = 0; i < NumPins; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = '0;
      if (!filter_en_i[i])
        filt_d[i] = sync2_q[i];
      else if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] >= thr_m1)
          filt_d[i] = sync2_q[i];
        else
          cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  // edge events set status bits; a set in the same cycle beats a clear
  always_comb begin
    intr_d = (intr_q & ~intr_clr_i)
           | (filt_d & ~filt_q & intr_rise_en_i)
           | (~filt_d & filt_q & intr_fall_en_i);
  end
  // state registers; disabled inputs are masked to 0 before the synchronizer so X never propagates
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q   <= '0;
      oe_q    <= '0;
      ie_q    <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      intr_q  <= '0;
      for (int i = 0; i < NumPins; i++) cnt_q[i] <= '0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      ie_q    <= ie_i;
      sync1_q <= pad_in_i & ie_q;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      intr_q  <= intr_d;
      for (int i = 0; i < NumPins; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign pad_out_o    = out_q;
  assign pad_oe_o     = oe_q;
  assign pad_ie_o     = ie_q;
  assign data_in_o    = filt_q;
  assign intr_state_o = intr_q;
  assign intr_o       = |intr_q;
endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: scoreboard bench with a window-based reference model of the pad controller
module tb_gpio_pad_ctrl;
  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic       out_wr = 1'b0, oe_wr = 1'b0;
  logic [7:0] wr_mask = '0, wr_data = '0, ie = '0, fen = '0, thresh = '0;
  logic [7:0] rise_en = '0, fall_en = '0, clr = '0, pad_in = '0;
  logic [7:0] pad_out, pad_oe, pad_ie, data_in, intr_state;
  logic       intr;

  gpio_pad_ctrl #(.NumPins(8), .CntW(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .out_wr_i(out_wr), .oe_wr_i(oe_wr),
    .wr_mask_i(wr_mask), .wr_data_i(wr_data), .ie_i(ie), .filter_en_i(fen),
    .filter_thresh_i(thresh), .intr_rise_en_i(rise_en), .intr_fall_en_i(fall_en),
    .intr_clr_i(clr), .pad_out_o(pad_out), .pad_oe_o(pad_oe), .pad_ie_o(pad_ie),
    .pad_in_i(pad_in), .data_in_o(data_in), .intr_state_o(intr_state), .intr_o(intr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct packed {
    logic [7:0] out, oe, ie, din, ist;
    logic       irq;
  } exp_t;
  exp_t exp_q[$];

  // reference model: pipeline of masked samples plus a history window per edge
  logic [7:0] m_out, m_oe, m_ie, m_filt, m_intr;
  logic [7:0] samp[$];
  logic [7:0] h_s[$], h_f[$], h_en[$];

  task automatic model_clear();
    m_out = '0; m_oe = '0; m_ie = '0; m_filt = '0; m_intr = '0;
    samp.delete(); h_s.delete(); h_f.delete(); h_en.delete();
  endtask

  task automatic model_edge();
    logic [7:0] s2, nf;
    int t, n;
    bit ok;
    exp_t e;
    s2 = (samp.size() >= 2) ? samp[samp.size()-2] : 8'h00;
    samp.push_back(pad_in & m_ie);
    if (samp.size() > 4) void'(samp.pop_front());
    h_s.push_back(s2); h_f.push_back(m_filt); h_en.push_back(fen);
    if (h_s.size() > 300) begin
      void'(h_s.pop_front()); void'(h_f.pop_front()); void'(h_en.pop_front());
    end
    t = (thresh == 0) ? 1 : int'(thresh);
    n = h_s.size();
    nf = m_filt;
    for (int p = 0; p < 8; p++) begin
      if (!fen[p]) nf[p] = s2[p];
      else if (n >= t) begin
        ok = 1;
        for (int j = 0; j < t; j++)
          if (!h_en[n-1-j][p] || h_s[n-1-j][p] == h_f[n-1-j][p] || h_f[n-1-j][p] != m_filt[p]) ok = 0;
        if (ok) nf[p] = s2[p];
      end
    end
    m_intr = (m_intr & ~clr) | (nf & ~m_filt & rise_en) | (~nf & m_filt & fall_en);
    m_filt = nf;
    if (out_wr) m_out = (m_out & ~wr_mask) | (wr_data & wr_mask);
    if (oe_wr)  m_oe  = (m_oe  & ~wr_mask) | (wr_data & wr_mask);
    m_ie = ie;
    e.out = m_out; e.oe = m_oe; e.ie = m_ie; e.din = m_filt; e.ist = m_intr; e.irq = |m_intr;
    exp_q.push_back(e);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    out_wr = 1'b0; oe_wr = 1'b0; clr = '0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_outputs", {pad_out, pad_oe, pad_ie, data_in, intr_state, 7'b0, intr}, 48'h0);
    model_clear();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // monitor: every cycle the DUT presents a new output state, compare against the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_out", pad_out, e.out);
      chk("sb_oe", pad_oe, e.oe);
      chk("sb_ie", pad_ie, e.ie);
      chk("sb_din", data_in, e.din);
      chk("sb_ist", intr_state, e.ist);
      chk("sb_irq", intr, e.irq);
    end
  end

  initial begin
    model_clear();
    pad_in = 'x;
    do_reset();
    step();
    chk("post_rst_oe", pad_oe, 8'h00);
    chk("post_rst_din", data_in, 8'h00);
    pad_in = '0;
    // masked writes
    out_wr = 1; oe_wr = 1; wr_data = 8'hFF; wr_mask = 8'h0F;
    step();
    chk("mw1_out", pad_out, 8'h0F);
    chk("mw1_oe", pad_oe, 8'h0F);
    out_wr = 1; oe_wr = 1; wr_data = 8'h00; wr_mask = 8'h01;
    step();
    chk("mw2_out", pad_out, 8'h0E);
    chk("mw2_oe", pad_oe, 8'h0E);
    // input disabled: pad activity never reaches data_in
    ie = '0; rise_en = 8'hFF; fall_en = 8'hFF;
    for (int i = 0; i < 6; i++) begin pad_in = 8'($urandom); step(); end
    chk("ie0_din", data_in, 8'h00);
    chk("ie0_ist", intr_state, 8'h00);
    // unfiltered latency
    ie = 8'hFF; fen = '0; rise_en = 8'h01; fall_en = '0; pad_in = '0;
    steps(4);
    pad_in = 8'h01;
    step(); chk("unf_k", data_in, 8'h00);
    step(); chk("unf_k1", data_in, 8'h00);
    step(); chk("unf_k2", data_in, 8'h01);
    chk("unf_ist", intr_state, 8'h01);
    chk("unf_irq", intr, 1'b1);
    // glitch filter, T=4
    fen = 8'hFF; thresh = 8'd4; rise_en = 8'hFF; fall_en = '0; pad_in = '0;
    steps(10);
    clr = 8'hFF; step();
    pad_in = 8'hFF; steps(3);
    pad_in = 8'h00; steps(8);
    chk("glitch3_din", data_in, 8'h00);
    chk("glitch3_ist", intr_state, 8'h00);
    pad_in = 8'hFF; steps(4);
    pad_in = 8'h00;
    step(); chk("glitch4_k4", data_in, 8'h00);
    step(); chk("glitch4_k5", data_in, 8'hFF);
    steps(8);
    // interrupt set vs clear
    fen = '0; clr = 8'h01; step();
    chk("clr_bit0", intr_state, 8'hFE);
    rise_en = '0; pad_in = 8'h01; steps(4);
    fall_en = 8'h01; pad_in = 8'h00;
    steps(2);
    clr = 8'h01; step();
    chk("set_beats_clr", intr_state, 8'hFF);
    clr = 8'hFF; step();
    chk("clr_all", intr_state, 8'h00);
    rise_en = '0; fall_en = '0; pad_in = 8'h01; steps(4);
    rise_en = 8'h01; pad_in = 8'h00; steps(4);
    chk("fall_rise_only", intr_state, 8'h00);
    chk("fall_rise_only_irq", intr, 1'b0);
    // reset in the middle of a filter count, T=8
    rise_en = '0; fen = 8'hFF; thresh = 8'd8; pad_in = '0;
    steps(12);
    pad_in = 8'h01;
    steps(7);
    do_reset();
    chk("midcnt_din0", data_in, 8'h00);
    steps(10);
    chk("midcnt_10", data_in, 8'h00);
    step();
    chk("midcnt_11", data_in, 8'h01);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      out_wr = ($urandom_range(0, 99) < 15);
      oe_wr  = ($urandom_range(0, 99) < 15);
      wr_mask = 8'($urandom); wr_data = 8'($urandom);
      if ($urandom_range(0, 99) < 5) ie = 8'($urandom);
      if ($urandom_range(0, 99) < 5) fen = 8'($urandom);
      if ($urandom_range(0, 99) < 5) thresh = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 99) < 5) rise_en = 8'($urandom);
      if ($urandom_range(0, 99) < 5) fall_en = 8'($urandom);
      if ($urandom_range(0, 99) < 10) clr = 8'($urandom);
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 99) < 20) pad_in[b] = ~pad_in[b];
      step();
    end
    @(posedge clk); #2;
    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/gpio_pad_ctrl.md
# gpio_pad_ctrl

Core-side controller for a bank of bidirectional pads; it drives the pad wrapper's `out_i`/`oe_i`/`ie_i` and consumes its `in_o`. It holds output and output-enable state, updated by masked writes. On the input path it provides 2-flop synchronization, an optional per-pin glitch filter and rise/fall edge interrupt latches. It sits between the GPIO register interface and the per-pin pad wrappers.

## Interface
- `NumPins`, 8: number of pads controlled.
- `CntW`, 8: filter counter / threshold width.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `out_wr_i` in 1: strobe, masked write of output data.
- `oe_wr_i` in 1: strobe, masked write of output enable.
- `wr_mask_i` in NumPins: per-bit write mask (shared by both strobes).
- `wr_data_i` in NumPins: write data (shared by both strobes).
- `ie_i` in NumPins: input enable per pin (level).
- `filter_en_i` in NumPins: glitch filter enable per pin.
- `filter_thresh_i` in CntW: stable-cycle threshold; 0 is treated as 1.
- `intr_rise_en_i` in NumPins: rising-edge interrupt enable.
- `intr_fall_en_i` in NumPins: falling-edge interrupt enable.
- `intr_clr_i` in NumPins: one-cycle pulse, clears interrupt state bits.
- `pad_out_o` out NumPins: to pad wrapper `out_i`.
- `pad_oe_o` out NumPins: to pad wrapper `oe_i`.
- `pad_ie_o` out NumPins: to pad wrapper `ie_i`.
- `pad_in_i` in NumPins: from pad wrapper `in_o`; may be X/Z while the input is disabled.
- `data_in_o` out NumPins: synchronized, filtered input value.
- `intr_state_o` out NumPins: latched interrupt status.
- `intr_o` out 1: OR of `intr_state_o`.

## Operation
- **Output regs.** `out_q`, `oe_q` drive `pad_out_o`/`pad_oe_o` directly.
  - On the strobe: q <= (q & ~wr_mask_i) | (wr_data_i & wr_mask_i).
  - Both strobes may be asserted in the same cycle; each register is updated independently.
- **Input enable.** `ie_q` is a registered copy of `ie_i`; `pad_ie_o = ie_q`.
- **Sync.** Sampled value = `pad_in_i & ie_q`, which is X-safe because a disabled input reads 0. It passes through 2 flops, `sync1` and `sync2`.
- **Filter** (per pin, counter `cnt`, result `filt_q`):
  - `filter_en=0`: filt_q <= sync2; cnt <= 0.
  - `filter_en=1`, sync2 == filt_q: cnt <= 0.
  - `filter_en=1`, sync2 != filt_q, cnt < T-1 (T = max(thresh, 1)): cnt <= cnt+1.
  - `filter_en=1`, sync2 != filt_q, cnt >= T-1: filt_q <= sync2; cnt <= 0.
  - Changing `filter_thresh_i` mid-count takes effect with the next comparison. The counter never wraps; the >= comparison guards it.
- `data_in_o = filt_q`.
- **Events.** `rise = filt_d & ~filt_q`; `fall = ~filt_d & filt_q`, where `filt_d` is the next value of `filt_q`.
- **Interrupt state.**
  - intr_state <= (intr_state & ~intr_clr_i) | (rise & intr_rise_en_i) | (fall & intr_fall_en_i).
  - Set wins over a simultaneous clear.
  - Disabling an enable does not clear an already-latched bit.
- `intr_o = |intr_state_o`, combinational.
- **Reset (async, `rst_ni=0`).** All registers clear to 0, so `pad_out_o`, `pad_oe_o`, `pad_ie_o`, `data_in_o`, `intr_state_o` and `intr_o` are all 0. Assertion mid-filter discards `cnt` and any pending transition. After release, pins are tristated and inputs are disabled until configured.

## Timing
- **Write latency.** Strobe sampled at edge k -> `pad_out_o`/`pad_oe_o` change after edge k. `ie_i` -> `pad_ie_o`: 1 cycle.
- **Input latency** (new `pad_in_i` stable before edge k, with `ie_q=1`):
  - sync1 updates at k, sync2 at k+1.
  - Unfiltered: `filt_q` updates at k+2.
  - Filtered, threshold T: `filt_q` updates at k+1+T, provided sync2 holds for T consecutive cycles.
  - T=1 gives the same timing as unfiltered.
- **Interrupt latency.** `intr_state_o` sets at the same edge as the `filt_q` update; `intr_o` follows in the same cycle.
- **Pulse rejection.** A pulse lasting P cycles at sync2 is rejected if P < T. Each return to the held value restarts the count.
- **Filter enable change.** Toggling `filter_en` takes effect on the next edge. 1->0 passes the current sync2 through immediately.

## Test plan
- **Reset values.** Assert `rst_ni`=0 asynchronously mid-cycle -> every output is 0 immediately; after release, `pad_oe_o`=0 and `data_in_o`=0 with `pad_in_i`=X.
- **Masked write.** `out_q`=0x00; write data=0xFF, mask=0x0F -> 0x0F. Then data=0x00, mask=0x01 -> 0x0E. Same write with `oe_wr_i` also asserted -> `pad_oe_o`=0x0E.
- **Unfiltered latency.** `ie`=1, filter off, pin0 rises before edge k -> `data_in_o[0]`=1 at k+2. With rise enable set, `intr_state_o[0]`=1 and `intr_o`=1 at k+2. With `ie`=0, no change ever occurs.
- **Glitch filter, T=4.** A 3-cycle high pulse -> `data_in_o` stays 0 and no interrupt. A 4-cycle pulse -> `data_in_o`=1 at k+5.
- **Interrupt set vs clear.** Pre-latched bit: `intr_clr_i` pulse -> cleared next edge. A fall event coincident with clear, fall enable set -> bit stays 1. A fall with only the rise enable set -> no set.
- **Reset mid-count.** T=8; reset is asserted after 5 stable cycles -> on release `cnt`=0, `data_in_o`=0, and a full 8 stable cycles are needed to update.
